core_sched: RTL
===============

// Module: core_sched
// PURPOSE
//   Time-slice scheduler directly upstream of the shared rf/ram mux. Produces
//   the three core clock enables (cmo, dlo, pln) round-robin: one-hot or all-low.
//   A core is never switched out mid wishbone cycle. While all enables are low,
//   the mux routes the shared resources to the test port.
// PARAMETERS
//   CNT_W       16  width of slice length / slice counter
//   GAP_CYCLES  2   all-enables-low guard cycles between slices (0 = none)
//   OVR_W       8   width of saturating overrun counter
// PORTS
//   i_clk          in   1      clock
//   i_rst          in   1      reset, synchronous, active-high
//   i_run          in   1      1 = schedule cores; 0 = stop at next slice end
//   i_core_mask    in   3      core enable mask {pln,dlo,cmo}; 0 = skip core
//   i_slice_len    in   CNT_W  slice length in cycles; 0 treated as 1
//   i_bus_busy     in   1      shared wishbone cyc (mux o_wb_mem_cyc)
//   o_clk_cmo_en   out  1      cmo owns rf/ram/q
//   o_clk_dlo_en   out  1      dlo owns rf/ram/q
//   o_clk_pln_en   out  1      pln owns rf/ram/q
//   o_cur          out  2      owner: 0 none, 1 cmo, 2 dlo, 3 pln
//   o_slice_done   out  1      1-cycle pulse on entry to GAP
//   o_ovr_cnt      out  OVR_W  slices extended by DRAIN (saturating)
//   o_busy         out  1      state != IDLE
// BEHAVIOUR
//   All outputs registered. Reset: state IDLE; all enables 0; o_cur 0;
//     o_slice_done 0; o_ovr_cnt 0; o_busy 0; last-core pointer = pln
//     (first pick is cmo); counters 0. Reset mid-slice drops enables next edge.
//   Selection: next set bit of i_core_mask after the pointer, in order
//     cmo->dlo->pln->cmo. Wraps. Mask is sampled only at the selection point.
//   IDLE: if i_run & |i_core_mask, then go to RUN with the selected core.
//     Its enable is 1 from the same edge. Otherwise stay.
//   RUN: latch L = max(i_slice_len,1) on entry. Count 0..L-1.
//     On the edge after count==L-1: i_bus_busy=0 -> GAP, else DRAIN.
//     With no busy, the enable is high for exactly L cycles.
//   DRAIN: enable stays high. o_ovr_cnt +1 once on entry (saturate at max).
//     Go to GAP on the first cycle with i_bus_busy=0. No timeout.
//   GAP: all enables 0; o_cur 0; o_slice_done pulses on the entry edge.
//     Hold for GAP_CYCLES cycles, then select again:
//       i_run & |i_core_mask -> RUN;
//       else -> IDLE.
//     With GAP_CYCLES=0, the GAP state is skipped: the pulse still fires and
//     selection happens on the edge leaving RUN/DRAIN. The new core's enable
//     is 1 from that same edge, with no all-low cycle.
//   Pointer updates on each RUN entry.
//   i_run=0 during RUN/DRAIN: no truncation; the slice completes normally.
//   If the mask has one bit set, the same core is re-selected every slice,
//     with GAP between slices.
//   Invariant: at most one enable high in any cycle. o_cur is consistent
//     with the enables.
// TESTING
//   1. reset; i_run=1, mask=3'b111, L=4, busy=0, GAP=2
//      -> cmo 4 cyc, 2 low, dlo 4, 2 low, pln 4, then cmo; o_ovr_cnt stays 0.
//   2. mask=3'b101, L=3 -> order cmo, pln, cmo, pln; dlo enable never rises.
//   3. L=4, busy=1 during cycles 3..6 of the cmo slice
//      -> cmo enable high 7 cycles; o_ovr_cnt=1; o_slice_done on cycle 8.
//   4. i_slice_len=0 -> each enable high exactly 1 cycle per slice.
//   5. drop i_run mid dlo slice (L=8)
//      -> dlo completes 8 cycles, GAP, then IDLE; o_busy=0; all enables 0.
//   6. assert i_rst mid-DRAIN
//      -> next edge all outputs 0; after release with i_run=1, first core is cmo.
//      Plus: o_ovr_cnt saturates at 255 after 300 forced overruns.
//      Plus: one-hot assertion holds throughout all runs.

Source files
------------

// File: rtl/core_sched.sv
// rtl/core_sched.sv - round-robin time-slice scheduler producing one-hot core clock enables
module core_sched #(
    parameter int CNT_W      = 16,
    parameter int GAP_CYCLES = 2,
    parameter int OVR_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic [2:0]       i_core_mask,
    input  logic [CNT_W-1:0] i_slice_len,
    input  logic             i_bus_busy,
    output logic             o_clk_cmo_en,
    output logic             o_clk_dlo_en,
    output logic             o_clk_pln_en,
    output logic [1:0]       o_cur,
    output logic             o_slice_done,
    output logic [OVR_W-1:0] o_ovr_cnt,
    output logic             o_busy
);

    localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic [OVR_W-1:0] OVR_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [2:0]       en_q, en_d;
    logic [1:0]       cur_q, cur_d;
    logic             done_q, done_d;
    logic [OVR_W-1:0] ovr_q, ovr_d;
    logic             busy_q;

    logic [2:0]       pick;
    logic             can_start;
    logic [CNT_W-1:0] len_eff;
    logic             slice_end;
    logic             select_now;

    // Returns {valid, core}: first masked-in core after 'last', order cmo(0)->dlo(1)->pln(2)->cmo.
    function automatic logic [2:0] pick_core(input logic [1:0] last, input logic [2:0] mask);
        logic [2:0] r;
        logic [1:0] c;
        r = 3'b000;
        c = last;
        for (int k = 0; k < 3; k++) begin
            c = (c == 2'd2) ? 2'd0 : c + 2'd1;
            if (!r[2] && mask[c]) begin
                r = {1'b1, c};
            end
        end
        return r;
    endfunction

    // Candidate next owner and effective slice length, evaluated every cycle.
    always_comb begin
        pick      = pick_core(ptr_q, i_core_mask);
        can_start = i_run & pick[2];
        len_eff   = (i_slice_len == '0) ? CNT_W'(1) : i_slice_len;
    end

    // Next-state and next-output logic; all outputs are registered from these values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        gap_d      = gap_q;
        ptr_d      = ptr_q;
        en_d       = en_q;
        cur_d      = cur_q;
        done_d     = 1'b0;
        ovr_d      = ovr_q;
        slice_end  = 1'b0;
        select_now = 1'b0;

        case (state_q)
            S_IDLE: begin
                select_now = 1'b1;
            end
            S_RUN: begin
                if (cnt_q == len_q - 1'b1) begin
                    if (i_bus_busy) begin
                        // never pull the core out from under an open bus cycle
                        state_d = S_DRAIN;
                        if (ovr_q != OVR_MAX) begin
                            ovr_d = ovr_q + 1'b1;
                        end
                    end else begin
                        slice_end = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (!i_bus_busy) begin
                    slice_end = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    select_now = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (slice_end) begin
            done_d = 1'b1;
            if (GAP_CYCLES == 0) begin
                // no guard band: hand over directly on this edge
                select_now = 1'b1;
            end else begin
                state_d = S_GAP;
                gap_d   = '0;
                en_d    = 3'b000;
                cur_d   = 2'd0;
            end
        end

        if (select_now) begin
            if (can_start) begin
                state_d = S_RUN;
                cnt_d   = '0;
                len_d   = len_eff;
                ptr_d   = pick[1:0];
                en_d    = 3'b001 << pick[1:0];
                cur_d   = pick[1:0] + 2'd1;
            end else begin
                state_d = S_IDLE;
                en_d    = 3'b000;
                cur_d   = 2'd0;
            end
        end
    end

    // State and output registers; pointer resets to pln so the first pick is cmo.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            ptr_q   <= 2'd2;
            en_q    <= 3'b000;
            cur_q   <= 2'd0;
            done_q  <= 1'b0;
            ovr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            ptr_q   <= ptr_d;
            en_q    <= en_d;
            cur_q   <= cur_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign o_clk_cmo_en = en_q[0];
    assign o_clk_dlo_en = en_q[1];
    assign o_clk_pln_en = en_q[2];
    assign o_cur        = cur_q;
    assign o_slice_done = done_q;
    assign o_ovr_cnt    = ovr_q;
    assign o_busy       = busy_q;

endmodule
